// File: rtl/regfile.sv
// Architectural integer register file with a load-use scoreboard.
// Two combinational read ports with write-through bypass, one write-back
// port, and a per-register busy vector that flags registers still waiting
// on an in-flight load so ID can be stalled on a load-use dependency.
module regfile #(
  parameter int NREGS = 32,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [DW-1:0]    wdata_i,
  input  logic             wload_i,
  input  logic [AW-1:0]    raddr1_i,
  input  logic [AW-1:0]    raddr2_i,
  output logic [DW-1:0]    rdata1_o,
  output logic [DW-1:0]    rdata2_o,
  input  logic             rs1_used_i,
  input  logic             rs2_used_i,
  input  logic [AW-1:0]    rs1_i,
  input  logic [AW-1:0]    rs2_i,
  input  logic             ld_issue_i,
  input  logic [AW-1:0]    ld_rd_i,
  input  logic             flush_i,
  output logic             stall_o,
  output logic [NREGS-1:0] busy_o
);

  // x0 has no storage; its reads are forced to zero below.
  logic [DW-1:0]    regs [1:NREGS-1];
  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;
  logic             wb_load;
  logic             haz1;
  logic             haz2;

  assign wb_load = we_i & wload_i & (waddr_i != '0);

  // Register storage: single write port, writes to x0 discarded.
  // NOTE: the array is reset on purpose -- reset must leave every register
  // reading as zero, so it cannot be left to power-up contents (this also
  // keeps it out of a plain RAM macro).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (we_i && (waddr_i != '0)) begin
      // NOTE: sequential state uses non-blocking assignment so every
      // register samples pre-edge values regardless of block ordering.
      regs[waddr_i] <= wdata_i;
    end
  end

  // Read port 1: x0 is zero, then write-through bypass, then storage.
  // Reads are also forced to zero while reset is held, so an active
  // write-back cannot leak through the bypass during reset.
  always_comb begin
    // NOTE: assigning a default first in every always_comb guarantees no
    // path leaves the output unassigned, so no latch is inferred.
    rdata1_o = '0;
    if (rst_n && (raddr1_i != '0)) begin
      if (we_i && (waddr_i == raddr1_i)) rdata1_o = wdata_i;
      else                               rdata1_o = regs[raddr1_i];
    end
  end

  // Read port 2: same rules as port 1.
  always_comb begin
    rdata2_o = '0;
    if (rst_n && (raddr2_i != '0)) begin
      if (we_i && (waddr_i == raddr2_i)) rdata2_o = wdata_i;
      else                               rdata2_o = regs[raddr2_i];
    end
  end

  // Scoreboard next state: flush clears everything and drops the issuing
  // load; otherwise the load write-back clears and the issuing load sets.
  // The set is applied after the clear so that a collision on the same
  // register keeps the bit for the newer load.
  always_comb begin
    busy_d = busy_q;
    if (flush_i) begin
      busy_d = '0;
    end else begin
      if (wb_load)                         busy_d[waddr_i] = 1'b0;
      if (ld_issue_i && (ld_rd_i != '0))   busy_d[ld_rd_i] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  // Load-use hazard: a busy source stalls unless its value is arriving on
  // the write-back bypass in this very cycle.
  assign haz1 = rs1_used_i & busy_q[rs1_i] & ~(we_i & wload_i & (waddr_i == rs1_i));
  assign haz2 = rs2_used_i & busy_q[rs2_i] & ~(we_i & wload_i & (waddr_i == rs2_i));

  assign stall_o = haz1 | haz2;
  assign busy_o  = busy_q;

endmodule

// File: tb/tb_regfile.sv
// Self-checking bench for regfile: a driver applies one stimulus per cycle
// and pushes the reference model's expected outputs into a queue; a monitor
// pops and compares on every falling edge.
module tb_regfile;

  localparam int NREGS = 32;
  localparam int AW    = 5;
  localparam int DW    = 32;

  typedef struct {
    logic          rst_n;
    logic          pulse;     // reset released mid-cycle, before next edge
    logic          we;
    logic          wload;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic [AW-1:0] raddr1;
    logic [AW-1:0] raddr2;
    logic          rs1_used;
    logic          rs2_used;
    logic [AW-1:0] rs1;
    logic [AW-1:0] rs2;
    logic          ld_issue;
    logic [AW-1:0] ld_rd;
    logic          flush;
  } stim_t;

  typedef struct {
    logic [DW-1:0]    rd1;
    logic [DW-1:0]    rd2;
    logic             stall;
    logic [NREGS-1:0] busy;
  } exp_t;

  logic             clk;
  logic             rst_n;
  logic             we_i, wload_i, rs1_used_i, rs2_used_i, ld_issue_i, flush_i;
  logic [AW-1:0]    waddr_i, raddr1_i, raddr2_i, rs1_i, rs2_i, ld_rd_i;
  logic [DW-1:0]    wdata_i, rdata1_o, rdata2_o;
  logic             stall_o;
  logic [NREGS-1:0] busy_o;

  int n_checks = 0;
  int n_errors = 0;

  exp_t exp_q[$];

  // Reference model: register values and the set of pending load targets.
  logic [DW-1:0] mem [NREGS];
  bit            pending [int];

  regfile #(.NREGS(NREGS), .AW(AW), .DW(DW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .we_i       (we_i),
    .waddr_i    (waddr_i),
    .wdata_i    (wdata_i),
    .wload_i    (wload_i),
    .raddr1_i   (raddr1_i),
    .raddr2_i   (raddr2_i),
    .rdata1_o   (rdata1_o),
    .rdata2_o   (rdata2_o),
    .rs1_used_i (rs1_used_i),
    .rs2_used_i (rs2_used_i),
    .rs1_i      (rs1_i),
    .rs2_i      (rs2_i),
    .ld_issue_i (ld_issue_i),
    .ld_rd_i    (ld_rd_i),
    .flush_i    (flush_i),
    .stall_o    (stall_o),
    .busy_o     (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '{rst_n: 1'b1, pulse: 1'b0, we: 1'b0, wload: 1'b0, waddr: '0, wdata: '0,
          raddr1: '0, raddr2: '0, rs1_used: 1'b0, rs2_used: 1'b0, rs1: '0, rs2: '0,
          ld_issue: 1'b0, ld_rd: '0, flush: 1'b0};
    return s;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < NREGS; i++) mem[i] = '0;
    pending.delete();
  endfunction

  function automatic logic [DW-1:0] model_read(input stim_t s, input int a);
    if (!s.rst_n || a == 0)           return '0;
    if (s.we && int'(s.waddr) == a)   return s.wdata;
    return mem[a];
  endfunction

  function automatic logic model_haz(input stim_t s, input logic used, input int rs);
    if (!used || !pending.exists(rs)) return 1'b0;
    return !(s.we && s.wload && int'(s.waddr) == rs);
  endfunction

  function automatic exp_t model_expect(input stim_t s);
    exp_t e;
    e.rd1   = model_read(s, int'(s.raddr1));
    e.rd2   = model_read(s, int'(s.raddr2));
    e.stall = model_haz(s, s.rs1_used, int'(s.rs1)) | model_haz(s, s.rs2_used, int'(s.rs2));
    e.busy  = '0;
    foreach (pending[r]) e.busy[r] = 1'b1;
    return e;
  endfunction

  // Architectural effect of one clock edge with the given inputs.
  function automatic void model_edge(input stim_t s);
    if (!s.rst_n) begin
      model_clear();
      return;
    end
    if (s.we && s.waddr != 0) mem[s.waddr] = s.wdata;
    if (s.flush) begin
      pending.delete();
    end else begin
      if (s.we && s.wload && s.waddr != 0) pending.delete(int'(s.waddr));
      if (s.ld_issue && s.ld_rd != 0)      pending[int'(s.ld_rd)] = 1'b1;
    end
  endfunction

  // One cycle: drive just after a rising edge, queue the expectation, then
  // advance the model across the next rising edge.
  task automatic step(input stim_t s);
    rst_n      = s.rst_n;
    we_i       = s.we;
    wload_i    = s.wload;
    waddr_i    = s.waddr;
    wdata_i    = s.wdata;
    raddr1_i   = s.raddr1;
    raddr2_i   = s.raddr2;
    rs1_used_i = s.rs1_used;
    rs2_used_i = s.rs2_used;
    rs1_i      = s.rs1;
    rs2_i      = s.rs2;
    ld_issue_i = s.ld_issue;
    ld_rd_i    = s.ld_rd;
    flush_i    = s.flush;
    if (!s.rst_n) model_clear();
    exp_q.push_back(model_expect(s));
    if (s.pulse) begin
      #6;               // past the falling-edge sample, before the next edge
      rst_n   = 1'b1;
      s.rst_n = 1'b1;
    end
    @(posedge clk);
    model_edge(s);
    #1;
  endtask

  // Monitor: outputs are combinational, so each falling edge presents one
  // response to be matched against the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("rdata1", 64'(rdata1_o), 64'(e.rd1));
        check("rdata2", 64'(rdata2_o), 64'(e.rd2));
        check("stall",  64'(stall_o),  64'(e.stall));
        check("busy",   64'(busy_o),   64'(e.busy));
      end
    end
  end

  initial begin
    stim_t s;
    model_clear();
    rst_n = 1'b0;
    @(posedge clk);
    #1;

    // Reset held, with a write-back that must not leak through the bypass.
    s = idle(); s.rst_n = 1'b0; s.we = 1'b1; s.waddr = 5; s.wdata = 32'h1111_2222;
    s.raddr1 = 5; s.raddr2 = 0;
    step(s); step(s);
    // Write to x0 is discarded, including on the bypass.
    s = idle(); s.we = 1'b1; s.waddr = 0; s.wdata = 32'hDEAD_BEEF; s.raddr1 = 0; s.raddr2 = 0;
    step(s);
    s = idle(); s.raddr1 = 0; s.raddr2 = 5; step(s);
    s = idle(); s.raddr1 = 5; s.raddr2 = 0; step(s);

    // Write then read: bypass in N, storage in N+1.
    s = idle(); s.we = 1'b1; s.waddr = 7; s.wdata = 32'h1234_5678; s.raddr1 = 7; s.raddr2 = 1;
    step(s);
    s = idle(); s.raddr1 = 7; s.raddr2 = 1; step(s);

    // Load-use stall on x3.
    s = idle(); s.ld_issue = 1'b1; s.ld_rd = 3; step(s);
    s = idle(); s.rs1 = 3; s.rs1_used = 1'b1; s.raddr1 = 3;
    step(s); step(s); step(s);
    s.we = 1'b1; s.wload = 1'b1; s.waddr = 3; s.wdata = 32'h0000_00A5;
    step(s);
    s = idle(); s.rs1 = 3; s.rs1_used = 1'b1; s.raddr1 = 3; step(s);

    // Set/clear collision on x4, then to different registers.
    s = idle(); s.ld_issue = 1'b1; s.ld_rd = 4; step(s);
    s = idle(); s.we = 1'b1; s.wload = 1'b1; s.waddr = 4; s.wdata = 32'h4444;
    s.ld_issue = 1'b1; s.ld_rd = 4; step(s);
    s = idle(); s.rs2 = 4; s.rs2_used = 1'b1; step(s);
    s = idle(); s.we = 1'b1; s.wload = 1'b1; s.waddr = 4; s.wdata = 32'h4445;
    s.ld_issue = 1'b1; s.ld_rd = 9; step(s);
    s = idle(); s.rs1 = 9; s.rs1_used = 1'b1; s.rs2 = 4; s.rs2_used = 1'b1; step(s);

    // Flush and non-load write.
    s = idle(); s.ld_issue = 1'b1; s.ld_rd = 2; step(s);
    s = idle(); s.ld_issue = 1'b1; s.ld_rd = 6; step(s);
    s = idle(); s.we = 1'b1; s.waddr = 2; s.wdata = 32'h2222; s.raddr1 = 2; step(s);
    s = idle(); s.flush = 1'b1; s.ld_issue = 1'b1; s.ld_rd = 8; s.rs1 = 6; s.rs1_used = 1'b1;
    step(s);
    s = idle(); s.rs1 = 8; s.rs1_used = 1'b1; s.rs2 = 2; s.rs2_used = 1'b1; step(s);

    // Reset pulse mid-operation with x5 busy and holding 0x55.
    s = idle(); s.we = 1'b1; s.waddr = 5; s.wdata = 32'h55; s.ld_issue = 1'b1; s.ld_rd = 5;
    step(s);
    s = idle(); s.raddr1 = 5; s.rs1 = 5; s.rs1_used = 1'b1; step(s);
    s.rst_n = 1'b0; s.pulse = 1'b1; step(s);
    s = idle(); s.raddr1 = 5; s.rs1 = 5; s.rs1_used = 1'b1; step(s);

    // Randomized traffic over a small register window to provoke hazards.
    for (int n = 0; n < 400; n++) begin
      s = idle();
      s.we       = ($urandom_range(0, 2) != 0);
      s.wload    = $urandom_range(0, 1) == 1;
      s.waddr    = AW'($urandom_range(0, 7));
      s.wdata    = $urandom;
      s.raddr1   = AW'($urandom_range(0, 7));
      s.raddr2   = AW'($urandom_range(0, 31));
      s.rs1_used = $urandom_range(0, 1) == 1;
      s.rs2_used = $urandom_range(0, 1) == 1;
      s.rs1      = AW'($urandom_range(0, 7));
      s.rs2      = AW'($urandom_range(0, 7));
      s.ld_issue = $urandom_range(0, 1) == 1;
      s.ld_rd    = AW'($urandom_range(0, 7));
      s.flush    = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 99) == 0) begin
        s.rst_n = 1'b0;
        s.pulse = 1'b1;
      end
      step(s);
    end

    @(negedge clk);
    #1;
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/regfile.md
# regfile

Architectural integer register file with a load-use scoreboard. It answers the read addresses issued by the ID-stage operand-forwarding logic and accepts the single write-back from the WB stage. It also tracks registers whose value is still pending from an in-flight load, and raises a stall request when ID reads such a register.

## Interface
Parameters:
- NREGS, 32, number of architectural registers; index 0 is hardwired to zero.
- AW, 5, register address width (RegAddrBus); must satisfy 2^AW = NREGS.
- DW, 32, data width (RegBus).

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- we_i  in  1  write-back enable from WB.
- waddr_i  in  AW  write-back destination register.
- wdata_i  in  DW  write-back data.
- wload_i  in  1  the write-back is the result of a load; qualified by we_i.
- raddr1_i  in  AW  read address, port 1, from the forwarding logic.
- raddr2_i  in  AW  read address, port 2, from the forwarding logic.
- rdata1_o  out  DW  read data, port 1.
- rdata2_o  out  DW  read data, port 2.
- rs1_used_i  in  1  the ID instruction consumes rs1.
- rs2_used_i  in  1  the ID instruction consumes rs2.
- rs1_i  in  AW  ID rs1 field, used for the hazard check.
- rs2_i  in  AW  ID rs2 field, used for the hazard check.
- ld_issue_i  in  1  a load leaves ID this cycle.
- ld_rd_i  in  AW  destination register of that load.
- flush_i  in  1  pipeline flush.
- stall_o  out  1  load-use stall request to the pipeline control.
- busy_o  out  NREGS  scoreboard vector, for debug and verification.

## Operation
- Storage: regs[1..NREGS-1], each DW bits. No storage exists for x0; its read value is the constant 0.
- Write:
  - On the clock edge, if we_i = 1 and waddr_i != 0, then regs[waddr_i] <= wdata_i.
  - A write with waddr_i = 0 is discarded.
- Read (combinational, per port n):
  - raddrn_i = 0 -> rdatan_o = 0.
  - Else if we_i = 1 and waddr_i = raddrn_i -> rdatan_o = wdata_i (write-through bypass).
  - Else rdatan_o = regs[raddrn_i].
- Scoreboard busy[NREGS-1:0]; busy[0] is always 0. Next-state priority, highest first:
  1. flush_i = 1: all bits cleared. ld_issue_i is ignored in that cycle.
  2. Set: if ld_issue_i = 1 and ld_rd_i != 0, then busy[ld_rd_i] <= 1.
  3. Clear: if we_i = 1, wload_i = 1 and waddr_i != 0, then busy[waddr_i] <= 0.
  - When set and clear target the same register in one cycle, the set wins (it belongs to the newer load).
  - Set and clear to different registers both take effect.
- Hazard, per source n:
  - hazn = rsn_used_i & busy[rsn_i] & ~(we_i & wload_i & waddr_i = rsn_i).
  - Data arriving this cycle on the write-back bypass does not stall.
  - stall_o = haz1 | haz2, combinational.
- Non-load writes (wload_i = 0) never modify busy.

## Timing
- Reset (rst_n = 0, asynchronous): every regs entry = 0 and busy = 0. While reset is held, rdatan_o = 0, stall_o = 0 and busy_o = 0.
- Read latency 0: rdatan_o follows raddrn_i, we_i, waddr_i and wdata_i in the same cycle.
- A write becomes visible from storage in cycle N+1. In cycle N it is visible only through the bypass.
- Scoreboard latency 1:
  - A load issued in cycle N sets busy in N+1.
  - stall_o can first assert in N+1, when the dependent instruction sits in ID.
- A load write-back in cycle M clears busy at the edge ending M. stall_o is already 0 during M because of the bypass term.
- Reset asserted mid-operation aborts pending writes; registers and busy clear immediately.
- No handshake is required on the write port. WB guarantees at most one write per cycle.

## Test plan
- Reset/x0:
  - Stimulus: hold rst_n = 0; then release; write 0xDEADBEEF to x0; read x0 and x5 on both ports.
  - Required response: all reads return 0, stall_o = 0, busy_o = 0.
- Write then read:
  - Stimulus: write x7 = 0x12345678 in cycle N, with raddr1_i = 7 in cycle N; hold raddr1_i = 7 in N+1.
  - Required response: rdata1_o = 0x12345678 in N via bypass and in N+1 from storage; rdata2_o unaffected.
- Load-use stall:
  - Stimulus: ld_issue_i = 1, ld_rd_i = 3 in cycle N; in N+1 drive rs1_i = 3, rs1_used_i = 1.
  - Required response: busy_o[3] = 1 and stall_o = 1 in N+1. stall_o stays 1 until the cycle with we_i = 1, wload_i = 1, waddr_i = 3, wdata_i = 0xA5. In that cycle stall_o = 0 and rdata1_o = 0xA5 for raddr1_i = 3. busy_o[3] = 0 afterwards.
- Set/clear collision:
  - Stimulus: in the same cycle, load write-back to x4 and ld_issue_i = 1 with ld_rd_i = 4.
  - Required response: busy_o[4] = 1 next cycle.
  - Repeat with ld_rd_i = 9: busy_o[4] = 0 and busy_o[9] = 1.
- Flush and non-load write:
  - Stimulus: set busy for x2 and x6; issue a non-load write to x2; then flush_i = 1 together with ld_issue_i = 1, ld_rd_i = 8.
  - Required response: after the non-load write, busy_o[2] stays 1. After the flush, busy_o = 0 (x8 is not set).
- Reset mid-operation:
  - Stimulus: with busy_o[5] = 1 and x5 = 0x55, pulse rst_n low between clock edges.
  - Required response: busy_o = 0, rdata for x5 = 0 and stall_o = 0 immediately, without waiting for a clock edge.
